// File: rtl/buzzer_arbiter_if.sv
// Request/status bundle between the lock control logic and the buzzer arbiter.
interface buzzer_arbiter_if;
  logic       req_key;
  logic       req_ok;
  logic       req_fail;
  logic       mute;
  logic       buzzer;
  logic       busy;
  logic [1:0] active_id;

  modport master (
    output req_key, req_ok, req_fail, mute,
    input  buzzer, busy, active_id
  );

  modport slave (
    input  req_key, req_ok, req_fail, mute,
    output buzzer, busy, active_id
  );
endinterface

// File: rtl/buzzer_arbiter.sv
// Fixed-priority, preempting sequencer sharing one piezo buzzer among
// key-click, unlock-success and wrong-password tone patterns.
module buzzer_arbiter #(
  parameter int unsigned KEY_HALF    = 50000,
  parameter int unsigned KEY_LEN     = 10000000,
  parameter int unsigned OK_HALF     = 25000,
  parameter int unsigned OK_LEN      = 30000000,
  parameter int unsigned FAIL_HALF   = 100000,
  parameter int unsigned FAIL_LEN    = 15000000,
  parameter int unsigned FAIL_GAP_LO = 5000000,
  parameter int unsigned FAIL_GAP_HI = 10000000
) (
  input logic             clk,
  input logic             rst_n,
  buzzer_arbiter_if.slave bus
);

  localparam int unsigned DUR_W  = 32;
  localparam int unsigned HALF_W = 24;

  // State value doubles as active_id and as the priority rank.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    KEY  = 2'd1,
    OK   = 2'd2,
    FAIL = 2'd3
  } state_t;

  state_t              state;
  logic [DUR_W-1:0]    dur_cnt;
  logic [HALF_W-1:0]   half_cnt;
  logic                tone;
  logic                buzzer_q;
  logic                busy_q;

  state_t              req_c;
  logic                start_c;
  logic [DUR_W-1:0]    len_lim_c;
  logic [HALF_W-1:0]   half_lim_c;
  state_t              state_nxt_c;
  logic [DUR_W-1:0]    dur_nxt_c;
  logic [HALF_W-1:0]   half_nxt_c;
  logic                tone_nxt_c;
  logic                gap_c;
  logic                buzzer_nxt_c;

  // Highest-priority request this cycle; lower simultaneous requests are dropped.
  always_comb begin
    req_c = IDLE;
    if (bus.req_fail)     req_c = FAIL;
    else if (bus.req_ok)  req_c = OK;
    else if (bus.req_key) req_c = KEY;
  end

  // Equal rank restarts, higher rank preempts, lower rank is ignored.
  assign start_c = (req_c != IDLE) && (2'(req_c) >= 2'(state));

  always_comb begin
    len_lim_c  = '0;
    half_lim_c = '0;
    case (state)
      KEY: begin
        len_lim_c  = DUR_W'(KEY_LEN - 1);
        half_lim_c = HALF_W'(KEY_HALF - 1);
      end
      OK: begin
        len_lim_c  = DUR_W'(OK_LEN - 1);
        half_lim_c = HALF_W'(OK_HALF - 1);
      end
      FAIL: begin
        len_lim_c  = DUR_W'(FAIL_LEN - 1);
        half_lim_c = HALF_W'(FAIL_HALF - 1);
      end
      default: begin
        len_lim_c  = '0;
        half_lim_c = '0;
      end
    endcase
  end

  // A start request wins over the natural end of the running pattern.
  always_comb begin
    state_nxt_c = state;
    dur_nxt_c   = dur_cnt;
    half_nxt_c  = half_cnt;
    tone_nxt_c  = tone;
    if (start_c) begin
      state_nxt_c = req_c;
      dur_nxt_c   = '0;
      half_nxt_c  = '0;
      tone_nxt_c  = 1'b1;
    end else if (state != IDLE) begin
      if (dur_cnt == len_lim_c) begin
        state_nxt_c = IDLE;
        dur_nxt_c   = '0;
        half_nxt_c  = '0;
        tone_nxt_c  = 1'b0;
      end else begin
        dur_nxt_c = dur_cnt + DUR_W'(1);
        if (half_cnt == half_lim_c) begin
          half_nxt_c = '0;
          tone_nxt_c = ~tone;
        end else begin
          half_nxt_c = half_cnt + HALF_W'(1);
        end
      end
    end
  end

  // Gap only masks the output; the tone counters keep running underneath it.
  assign gap_c = (state_nxt_c == FAIL) &&
                 (dur_nxt_c > DUR_W'(FAIL_GAP_LO)) &&
                 (dur_nxt_c < DUR_W'(FAIL_GAP_HI));

  assign buzzer_nxt_c = (state_nxt_c != IDLE) & tone_nxt_c & ~gap_c & ~bus.mute;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      dur_cnt  <= '0;
      half_cnt <= '0;
      tone     <= 1'b0;
      buzzer_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt_c;
      dur_cnt  <= dur_nxt_c;
      half_cnt <= half_nxt_c;
      tone     <= tone_nxt_c;
      buzzer_q <= buzzer_nxt_c;
      busy_q   <= (state_nxt_c != IDLE);
    end
  end

  assign bus.buzzer    = buzzer_q;
  assign bus.busy      = busy_q;
  assign bus.active_id = 2'(state);

endmodule

// File: doc/buzzer_arbiter.md
# buzzer_arbiter

Shares the single piezo buzzer output among the lock's event sources: keypress click, unlock success and wrong-password fail. Each source issues a one-cycle request pulse. The block applies fixed priority and preemption, then generates the matching timed square-wave pattern. It sits between the password/keypad control logic and the buzzer pin, and replaces the inline per-event buzzer counters with one sequenced resource.

## Interface
Parameters:
- KEY_HALF, 50000: half-period of the key tone, in clk cycles.
- KEY_LEN, 10000000: duration of the key pattern, in cycles.
- OK_HALF, 25000: half-period of the success tone.
- OK_LEN, 30000000: duration of the success pattern.
- FAIL_HALF, 100000: half-period of the fail tone.
- FAIL_LEN, 15000000: duration of the fail pattern.
- FAIL_GAP_LO, 5000000: first cycle of the fail silent gap, exclusive bound.
- FAIL_GAP_HI, 10000000: end of the fail silent gap, exclusive bound.

Ports:
- clk, input, 1: system clock, 50 MHz.
- rst_n, input, 1: reset. Asynchronous, active-low.
- req_key, input, 1: keypress beep request, one-cycle pulse.
- req_ok, input, 1: success pattern request, one-cycle pulse.
- req_fail, input, 1: fail pattern request, one-cycle pulse.
- mute, input, 1: level signal. Forces buzzer to 0; sequencing continues.
- buzzer, output, 1: registered buzzer drive.
- busy, output, 1: high while any pattern is running.
- active_id, output, 2: running pattern. 0 = none, 1 = key, 2 = ok, 3 = fail.

## Operation
- State machine states: IDLE, KEY, OK, FAIL. The state is encoded directly as active_id. busy is high whenever the state is not IDLE.
- Priority order: FAIL > OK > KEY. When requests arrive in the same cycle, the highest-priority one is taken and the others are discarded.
- Start or preempt:
  - A request of strictly higher priority than the running pattern starts immediately.
  - A request of equal priority restarts the running pattern from its beginning.
  - A request of lower priority while busy is dropped. Requests are never queued.
- On start:
  - dur_cnt and half_cnt are set to 0.
  - The internal tone is set to 1.
  - State moves to the requested pattern.
- While running, every cycle:
  - dur_cnt increments.
  - half_cnt increments. When half_cnt equals HALF-1 for the active pattern, tone toggles and half_cnt returns to 0.
  - When dur_cnt equals LEN-1, the next state is IDLE, tone is 0, and both counters are cleared.
  - If a valid start request is present in that same cycle, it wins over the end of the pattern.
- Fail gap: in state FAIL, while FAIL_GAP_LO < dur_cnt < FAIL_GAP_HI, the gap flag is 1. The tone counters keep running during the gap, so the tone phase after the gap is continuous.
- Output: buzzer (registered) = tone & ~gap & ~mute. In IDLE, buzzer is 0.
- Counter widths: dur_cnt is 32 bits and half_cnt is 24 bits. Neither counter can wrap within any legal parameter set. Parameters are required to satisfy HALF ≥ 1 and LEN ≥ 2.
- Asserting mute never alters the state, the counters, busy or active_id.

## Timing
- Reset (rst_n = 0, asynchronous):
  - state is IDLE.
  - buzzer = 0, busy = 0, active_id = 0.
  - All counters are 0.
  - Reset mid-pattern aborts the pattern immediately. No pattern restarts after release.
- Request-to-output latency: a request sampled at edge N gives busy, active_id and buzzer = 1 valid after edge N.
- First toggle of buzzer: after edge N+HALF, where N is the start edge.
- Tone period is 2·HALF cycles.
- A pattern started at edge N:
  - busy falls after edge N+LEN.
  - Total busy time is LEN cycles.
- Back-to-back: a request in the cycle where dur_cnt = LEN-1 starts the new pattern with no idle cycle between the two.
- The fail gap silences buzzer for cycles FAIL_GAP_LO+1 … FAIL_GAP_HI-1 of the pattern, counted from the start edge and registered one cycle later.

## Test plan
Bench parameters: KEY_HALF=2, KEY_LEN=12, OK_HALF=1, OK_LEN=8, FAIL_HALF=3, FAIL_LEN=30, FAIL_GAP_LO=10, FAIL_GAP_HI=20.

1. Single req_key pulse at edge 5 -> busy high for edges 6–17, active_id = 1. buzzer pattern from edge 6 is 1,1,0,0,1,1,0,0,1,1,0,0. buzzer = 0 and busy = 0 from edge 18.
2. req_key and req_fail in the same cycle -> active_id = 3. busy lasts 30 cycles. buzzer = 0 for pattern cycles 11–19. The tone then resumes in phase.
3. req_ok running, req_key at ok-cycle 3 -> the key request is ignored; the OK pattern ends at its original end cycle 8. Then req_fail at ok-cycle 4 of a new OK pattern -> the switch to active_id = 3 happens on the next edge, with counters restarted.
4. req_key re-issued at key-cycle 7 -> the pattern restarts and busy extends to 12 cycles after the second pulse. A request at the final cycle (dur_cnt = 11) -> no idle gap; busy stays high.
5. mute held high during an OK pattern -> buzzer stays 0 throughout, while busy and active_id behave exactly as unmuted. Releasing mute mid-pattern -> buzzer follows the tone on the next edge.
6. rst_n pulsed low mid-FAIL, asynchronously between edges -> buzzer, busy and active_id all go to 0 immediately and stay 0 after release until a new request.
